// File: rtl/snn_pkg.sv
// Shared types and default widths for the neuron datapath output stage.
package snn_pkg;

  localparam int ACC_W = 26;
  localparam int SAT_W = 11;
  localparam int OUT_W = 8;

  // Adding this offset maps signed [-1024, 1023] onto LUT rows [0, 2047].
  localparam logic [SAT_W-1:0] LUT_OFFSET = 11'd1024;

  typedef enum logic [1:0] {IDLE, RD, WR} act_state_t;

endpackage

// File: rtl/act_out_stage_if.sv
// Accumulator hand-off from a neuron datapath into the activation output stage.
interface act_out_stage_if #(
  parameter int ACC_W = snn_pkg::ACC_W
);
  // Valid/ready: a transfer happens on the clock edge where acc_vld and acc_rdy
  // are both high; the master holds acc and acc_vld stable until that edge, and
  // acc_rdy never depends combinationally on acc_vld.
  logic signed [ACC_W-1:0] acc;
  logic                    acc_vld;
  logic                    acc_rdy;

  modport master (output acc, output acc_vld, input acc_rdy);
  modport slave  (input acc, input acc_vld, output acc_rdy);
endinterface

// File: rtl/act_sat.sv
// Rescale a signed accumulator by an arithmetic shift, clip it to SAT_W bits
// and turn the result into an unsigned activation-LUT address.
module act_sat
  import snn_pkg::*;
#(
  parameter int ACC_W = snn_pkg::ACC_W,
  parameter int SHIFT = 7,
  parameter int SAT_W = snn_pkg::SAT_W
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [SAT_W-1:0] lut_addr,
  output logic                    clipped
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] shifted;
  logic        [SAT_W-1:0] sat;

  always_comb begin
    shifted = acc >>> SHIFT;
    clipped = 1'b0;
    sat     = shifted[SAT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat     = SAT_MAX[SAT_W-1:0];
      clipped = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat     = SAT_MIN[SAT_W-1:0];
      clipped = 1'b1;
    end
    // Offset by 1024 is just an MSB flip for an 11-bit two's complement value.
    lut_addr = sat ^ LUT_OFFSET;
  end

endmodule

// File: rtl/act_out_stage.sv
// Activation output stage: accept final accumulator, saturate, read activation
// ROM, write layer output memory. Optional clip counter: ACT_OUT_STAGE_STATS_EN.
module act_out_stage
  import snn_pkg::*;
#(
  parameter int ACC_W       = snn_pkg::ACC_W,
  parameter int SHIFT       = 7,
  parameter int SAT_W       = snn_pkg::SAT_W,
  parameter int OUT_W       = snn_pkg::OUT_W,
  parameter int NUM_NEURONS = 32,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  act_out_stage_if.slave   acc_bus,
  input  logic             layer_start,
  output logic             lut_rd,
  output logic [SAT_W-1:0] lut_addr,
  input  logic [OUT_W-1:0] lut_data,
  output logic             out_we,
  output logic [IDX_W-1:0] out_addr,
  output logic [OUT_W-1:0] out_data,
  output logic             layer_done,
  output logic             busy,
  output act_state_t       state_dbg
`ifdef ACT_OUT_STAGE_STATS_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  act_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [SAT_W-1:0] sat_reg;
  logic [SAT_W-1:0] sat_addr;
  logic             clipped;
  logic             pend;
  logic             rdy;
  logic             accept;
  logic             restart;

  act_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .SAT_W (SAT_W)
  ) u_sat (
    .acc      (acc_bus.acc),
    .lut_addr (sat_addr),
    .clipped  (clipped)
  );

  assign accept          = rdy & acc_bus.acc_vld;
  // A layer_start seen in RD or WR (latched or arriving now) retargets index 0.
  assign restart         = pend | layer_start;
  assign acc_bus.acc_rdy = rdy;
  assign lut_addr        = sat_reg;
  assign state_dbg       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    busy       = 1'b1;
    lut_rd     = 1'b0;
    out_we     = 1'b0;
    out_addr   = '0;
    out_data   = '0;
    layer_done = 1'b0;
    case (state)
      IDLE: begin
        rdy  = 1'b1;
        busy = 1'b0;
        if (acc_bus.acc_vld) state_nxt = RD;
      end
      RD: begin
        lut_rd    = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        out_we     = 1'b1;
        out_addr   = idx;
        out_data   = lut_data;
        layer_done = (idx == LAST_IDX) && !restart;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      sat_reg <= '0;
      pend    <= 1'b0;
    end else begin
      if (accept) sat_reg <= sat_addr;
      case (state)
        IDLE: if (layer_start) idx <= '0;
        RD:   if (layer_start) pend <= 1'b1;
        WR: begin
          pend <= 1'b0;
          idx  <= (restart || idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ACT_OUT_STAGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (layer_start) begin
      sat_cnt <= (accept && clipped) ? 16'd1 : 16'd0;
    end else if (accept && clipped && sat_cnt != 16'hFFFF) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`else
  logic unused_clipped;
  assign unused_clipped = clipped;
`endif

endmodule

// File: tb/tb_act_out_stage.sv
// Bench for act_out_stage: timeline model of accept/read/write plus directed
// vectors with literal expectations.
module tb_act_out_stage;
  import snn_pkg::*;

  localparam int ACC_W       = 26;
  localparam int SAT_W       = 11;
  localparam int OUT_W       = 8;
  localparam int NUM_NEURONS = 32;
  localparam int IDX_W       = 5;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             layer_start = 1'b0;
  logic             lut_rd;
  logic [SAT_W-1:0] lut_addr;
  logic [OUT_W-1:0] lut_data = '0;
  logic             out_we;
  logic [IDX_W-1:0] out_addr;
  logic [OUT_W-1:0] out_data;
  logic             layer_done;
  logic             busy;
  act_state_t       state_dbg;
`ifdef ACT_OUT_STAGE_STATS_EN
  logic [15:0]      sat_cnt;
`endif

  act_out_stage_if #(.ACC_W(ACC_W)) acc_bus ();

  always #10 clk = ~clk;

  act_out_stage #(
    .ACC_W       (ACC_W),
    .SHIFT       (7),
    .SAT_W       (SAT_W),
    .OUT_W       (OUT_W),
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_bus     (acc_bus.slave),
    .layer_start (layer_start),
    .lut_rd      (lut_rd),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .out_we      (out_we),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .layer_done  (layer_done),
    .busy        (busy),
    .state_dbg   (state_dbg)
`ifdef ACT_OUT_STAGE_STATS_EN
    ,
    .sat_cnt     (sat_cnt)
`endif
  );

  // Synchronous activation ROM with random contents.
  logic [OUT_W-1:0] rom [2048];
  always @(posedge clk) if (lut_rd) lut_data <= rom[lut_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_ld  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor_div128(input int a);
    int q;
    q = a / 128;
    if ((a % 128) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_addr(input int a);
    int q;
    q = floor_div128(a);
    if (q > 1023) q = 1023;
    if (q < -1024) q = -1024;
    return q + 1024;
  endfunction

  function automatic bit model_clip(input int a);
    int q;
    q = floor_div128(a);
    return (q > 1023) || (q < -1024);
  endfunction

  // Timeline model: an accept in cycle c reads in c+1, writes in c+2, ready in c+3.
  logic [15:0] exp_q[$];
  int cyc = 0;
  int rd_cyc = -1;
  int wr_cyc = -1;
  int ready_cyc = 0;
  int m_idx = 0;
  bit m_pend = 0;
  int m_lut = 0;
  int m_sat = 0;

  always @(negedge clk) begin : compare
    bit          exp_rdy;
    bit          restart;
    logic [15:0] ent;
    int          a;
    int          e_idx;
    int          e_addr;
    if (!rst_n) begin
      exp_q.delete();
      rd_cyc = -1; wr_cyc = -1; ready_cyc = cyc;
      m_idx = 0; m_pend = 0; m_lut = 0; m_sat = 0;
    end
    exp_rdy = (cyc >= ready_cyc);
    restart = m_pend || (rst_n && layer_start);
    chk("acc_rdy", acc_bus.acc_rdy, exp_rdy);
    chk("busy", busy, !exp_rdy);
    chk("lut_rd", lut_rd, cyc == rd_cyc);
    chk("lut_addr", lut_addr, m_lut);
`ifdef ACT_OUT_STAGE_STATS_EN
    chk("sat_cnt", sat_cnt, m_sat);
`endif
    if (layer_done) n_ld++;
    if (cyc == wr_cyc && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      e_idx  = int'(ent[15:11]);
      e_addr = int'(ent[10:0]);
      chk("out_we", out_we, 1);
      chk("out_addr", out_addr, e_idx);
      chk("out_data", out_data, rom[e_addr]);
      chk("layer_done", layer_done, (e_idx == NUM_NEURONS - 1) && !restart);
      m_idx  = (restart || e_idx == NUM_NEURONS - 1) ? 0 : e_idx + 1;
      m_pend = 0;
    end else begin
      chk("out_we_idle", out_we, 0);
      chk("out_data_idle", out_data, 0);
      chk("layer_done_idle", layer_done, 0);
    end
    if (rst_n && cyc == rd_cyc && layer_start) m_pend = 1;
    if (rst_n && layer_start) m_sat = 0;
    if (rst_n && exp_rdy && layer_start) m_idx = 0;
    if (rst_n && exp_rdy && acc_bus.acc_vld) begin
      a = int'(acc_bus.acc);
      exp_q.push_back({5'(m_idx), 11'(model_addr(a))});
      m_lut     = model_addr(a);
      rd_cyc    = cyc + 1;
      wr_cyc    = cyc + 2;
      ready_cyc = cyc + 3;
      if (model_clip(a) && m_sat < 65535) m_sat++;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  // Present a value and hold it until accepted; returns at posedge+1 of the RD cycle.
  task automatic send(input int a);
    bit got;
    got = 0;
    acc_bus.acc     = ACC_W'(a);
    acc_bus.acc_vld = 1'b1;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (acc_bus.acc_rdy) got = 1;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got no acc_rdy, expected acc_rdy within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  // Called right after send(); pins the RD and WR cycles to literal values.
  task automatic expect_rd_wr(input int lut_a, input int idx);
    acc_bus.acc_vld = 1'b0;
    @(negedge clk);
    chk("lit_lut_rd", lut_rd, 1);
    chk("lit_lut_addr", lut_addr, lut_a);
    @(negedge clk);
    chk("lit_out_we", out_we, 1);
    chk("lit_out_addr", out_addr, idx);
    chk("lit_out_data", out_data, rom[lut_a]);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    layer_start = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  // Neuron whose RD cycle sees layer_start: writes at idx, no layer_done.
  task automatic send_start_in_rd(input int a, input int idx);
    send(a);
    acc_bus.acc_vld = 1'b0;
    layer_start = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
    @(negedge clk);
    chk("lit_pend_addr", out_addr, idx);
    chk("lit_pend_we", out_we, 1);
    chk("lit_pend_ld", layer_done, 0);
    @(posedge clk); #1;
  endtask

  function automatic int rnd_acc();
    return int'($urandom_range(0, 400000)) - 200000;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int ld0;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
    acc_bus.acc = '0;
    acc_bus.acc_vld = 1'b0;

    chk("model_12800", model_addr(12800), 1124);
    chk("model_200000", model_addr(200000), 2047);
    chk("model_m300000", model_addr(-300000), 0);
    chk("model_m1", model_addr(-1), 1023);
    chk("model_0", model_addr(0), 1024);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc_rdy", acc_bus.acc_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_out_we", out_we, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(12800);   expect_rd_wr(1124, 0);
    send(200000);  expect_rd_wr(2047, 1);
    send(-300000); expect_rd_wr(0, 2);
    send(-1);      expect_rd_wr(1023, 3);
    send(0);       expect_rd_wr(1024, 4);

    // Full layer back to back, then wrap.
    pulse_start();
    ld0 = n_ld;
    for (int i = 0; i < NUM_NEURONS; i++) send(rnd_acc());
    send(6400);
    expect_rd_wr(1074, 0);
    chk("lit_layer_done_count", n_ld - ld0, 1);

    // layer_start during RD of neuron 5.
    pulse_start();
    for (int i = 0; i < 5; i++) send(rnd_acc());
    send_start_in_rd(-128, 5);
    send(127);
    expect_rd_wr(1024, 0);

    // layer_start during RD of the last neuron suppresses layer_done.
    ld0 = n_ld;
    for (int i = 1; i < NUM_NEURONS - 1; i++) send(rnd_acc());
    send_start_in_rd(129, 31);
    send(-129);
    expect_rd_wr(1022, 0);
    chk("lit_no_layer_done", n_ld - ld0, 0);

    // layer_start together with an accept in IDLE: written at index 0.
    send(256); expect_rd_wr(1026, 1);
    acc_bus.acc     = ACC_W'(512);
    acc_bus.acc_vld = 1'b1;
    layer_start     = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
    expect_rd_wr(1028, 0);

    // Reset in RD aborts the write; index back to 0.
    send(1000000);
    acc_bus.acc_vld = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_no_we", out_we, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_rst_no_we2", out_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_rdy", acc_bus.acc_rdy, 1);
    @(posedge clk); #1;
    send(-2000000); expect_rd_wr(0, 0);

`ifdef ACT_OUT_STAGE_STATS_EN
    pulse_start();
    send(200000);  expect_rd_wr(2047, 0);
    send(100);     expect_rd_wr(1024, 1);
    send(-300000); expect_rd_wr(0, 2);
    @(negedge clk);
    chk("lit_sat_cnt2", sat_cnt, 2);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    chk("lit_sat_cnt0", sat_cnt, 0);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++; n_bad++;
    $display("FAIL global_timeout: got no end of stimulus, expected it before 1 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
